// File: rtl/run_ctrl.sv
// Run controller: holds the core in reset, preloads data memory from a byte
// stream, releases the core and times its run. Optional checksum: RUN_CTRL_CHKSUM_EN.
module run_ctrl #(
    parameter int              AW      = 8,
    parameter int              CW      = 16,
    parameter logic [CW-1:0]   MAX_CYC = 16'hFFFF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   ld_len,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_dat,
    output logic          core_reset,
    input  logic          core_done,
    output logic          busy,
    output logic          finished,
    output logic          timeout,
    output logic [CW-1:0] cycles,
    output logic [7:0]    ld_sum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REL,
        S_RUN,
        S_DONE,
        S_TMO
    } state_t;

    localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
    localparam logic [CW-1:0] CYC_ONE = CW'(1);

    state_t          state_q, state_d;
    logic [AW:0]     len_q, len_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            relCnt_q, relCnt_d;
    logic [CW-1:0]   cycles_q, cycles_d;
    logic            wrEn_q, wrEn_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      dat_q, dat_d;
    logic            accept;
    logic            clearRun;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        relCnt_d = 1'b0;
        cycles_d = cycles_q;
        wrEn_d   = 1'b0;
        addr_d   = addr_q;
        dat_d    = dat_q;
        accept   = 1'b0;
        clearRun = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_TMO: begin
                if (start) begin
                    clearRun = 1'b1;
                    len_d    = ld_len;
                    cnt_d    = '0;
                    cycles_d = '0;
                    state_d  = (ld_len != '0) ? S_LOAD : S_REL;
                end
            end
            S_LOAD: begin
                if (ld_valid) begin
                    accept = 1'b1;
                    wrEn_d = 1'b1;
                    addr_d = cnt_q[AW-1:0];
                    dat_d  = ld_data;
                    cnt_d  = cnt_q + LEN_ONE;
                    if (cnt_q == len_q - LEN_ONE) begin
                        state_d = S_REL;
                    end
                end
            end
            S_REL: begin
                // Second release cycle hands the core over to RUN
                relCnt_d = 1'b1;
                if (relCnt_q) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (core_done) begin
                    state_d = S_DONE;
                end else if (cycles_q == MAX_CYC) begin
                    state_d = S_TMO;
                end else if (cycles_q != '1) begin
                    cycles_d = cycles_q + CYC_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            relCnt_q <= 1'b0;
            cycles_q <= '0;
            wrEn_q   <= 1'b0;
            addr_q   <= '0;
            dat_q    <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            relCnt_q <= relCnt_d;
            cycles_q <= cycles_d;
            wrEn_q   <= wrEn_d;
            addr_q   <= addr_d;
            dat_q    <= dat_d;
        end
    end

`ifdef RUN_CTRL_CHKSUM_EN
    logic [7:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clearRun) begin
            sum_d = '0;
        end else if (accept) begin
            sum_d = sum_q + ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign ld_sum = sum_q;
`else
    assign ld_sum = '0;
`endif

    // Handshake-facing and core-facing controls decode the state register only
    assign ld_ready   = (state_q == S_LOAD);
    assign busy       = (state_q == S_LOAD) || (state_q == S_REL) || (state_q == S_RUN);
    assign core_reset = !((state_q == S_RUN) || (state_q == S_DONE));
    assign finished   = (state_q == S_DONE);
    assign timeout    = (state_q == S_TMO);
    assign cycles     = cycles_q;
    assign mem_wr_en  = wrEn_q;
    assign mem_addr   = addr_q;
    assign mem_dat    = dat_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: randomized preload/run sequences against a
// transaction-level model of the expected writes, checksum and run outcome.
module tb_run_ctrl;

    localparam int AW  = 8;
    localparam int CW  = 16;
    localparam int MAX = 12;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW:0]   ld_len;
    logic          ld_valid;
    logic [7:0]    ld_data;
    logic          ld_ready;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_dat;
    logic          core_reset;
    logic          core_done;
    logic          busy;
    logic          finished;
    logic          timeout;
    logic [CW-1:0] cycles;
    logic [7:0]    ld_sum;

    int checks   = 0;
    int failures = 0;

    run_ctrl #(.AW(AW), .CW(CW), .MAX_CYC(16'd12)) dut (
        .clk(clk), .reset(reset), .start(start), .ld_len(ld_len),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_dat(mem_dat),
        .core_reset(core_reset), .core_done(core_done), .busy(busy),
        .finished(finished), .timeout(timeout), .cycles(cycles), .ld_sum(ld_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] expSum(input logic [7:0] sum);
`ifdef RUN_CTRL_CHKSUM_EN
        return sum;
`else
        return 8'h00;
`endif
    endfunction

    // One complete start/load/release/run sequence; doneAt<0 means the core never finishes
    task automatic applyStimulus(input int len, input int gapFixed, input bit fixedData,
                                 input int doneAt, input bit pulseStart);
        int         g;
        logic [7:0] b;
        logic [7:0] sum;
        int         expEnd;
        bit         isDone;
        sum      = 8'h00;
        start    = 1'b1;
        ld_len   = 9'(len);
        ld_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checkOutput("startBusy", busy, 1);
        checkOutput("startFinished", finished, 0);
        checkOutput("startTimeout", timeout, 0);
        checkOutput("startCycles", cycles, 0);
        checkOutput("startSum", ld_sum, 0);
        checkOutput("startReady", ld_ready, (len != 0));
        for (int k = 0; k < len; k++) begin
            g = (gapFixed >= 0) ? gapFixed : int'($urandom_range(2, 0));
            for (int i = 0; i < g; i++) begin
                ld_valid  = 1'b0;
                core_done = 1'($urandom);
                @(negedge clk);
                checkOutput("gapWrEn", mem_wr_en, 0);
                checkOutput("gapReady", ld_ready, 1);
            end
            b         = fixedData ? 8'((k + 1) * 17) : 8'($urandom);
            ld_valid  = 1'b1;
            ld_data   = b;
            core_done = 1'($urandom);
            @(negedge clk);
            checkOutput("wrEn", mem_wr_en, 1);
            checkOutput("wrAddr", mem_addr, k % 256);
            checkOutput("wrDat", mem_dat, b);
            checkOutput("readyAfterHs", ld_ready, (k != len - 1));
            sum = sum + b;
        end
        ld_valid = 1'b0;
        checkOutput("rel1CoreRst", core_reset, 1);
        checkOutput("rel1Busy", busy, 1);
        if (len == 0) checkOutput("rel1WrEn", mem_wr_en, 0);
        core_done = 1'($urandom);
        @(negedge clk);
        checkOutput("rel2CoreRst", core_reset, 1);
        checkOutput("rel2WrEn", mem_wr_en, 0);
        checkOutput("rel2Ready", ld_ready, 0);
        checkOutput("loadSum", ld_sum, expSum(sum));
        core_done = 1'($urandom);
        @(negedge clk);
        isDone = (doneAt >= 0) && (doneAt <= MAX);
        expEnd = isDone ? doneAt : MAX;
        for (int n = 0; n <= expEnd; n++) begin
            checkOutput("runCycles", cycles, n);
            checkOutput("runCoreRst", core_reset, 0);
            checkOutput("runBusy", busy, 1);
            core_done = isDone && (n == expEnd);
            start     = pulseStart && (n == 1) && (n < expEnd);
            @(negedge clk);
            start = 1'b0;
        end
        checkOutput("endFinished", finished, isDone);
        checkOutput("endTimeout", timeout, !isDone);
        checkOutput("endCycles", cycles, expEnd);
        checkOutput("endCoreRst", core_reset, !isDone);
        checkOutput("endBusy", busy, 0);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        checkOutput("holdCycles", cycles, expEnd);
        checkOutput("holdFinished", finished, isDone);
        checkOutput("holdSum", ld_sum, expSum(sum));
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        ld_len    = '0;
        ld_valid  = 1'b0;
        ld_data   = '0;
        core_done = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rstCoreRst", core_reset, 1);
        checkOutput("rstReady", ld_ready, 0);
        checkOutput("rstWrEn", mem_wr_en, 0);
        checkOutput("rstAddr", mem_addr, 0);
        checkOutput("rstDat", mem_dat, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstFinished", finished, 0);
        checkOutput("rstTimeout", timeout, 0);
        checkOutput("rstCycles", cycles, 0);
        checkOutput("rstSum", ld_sum, 0);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus(3, 0, 1'b1, 5, 1'b0);
        applyStimulus(3, 2, 1'b0, 3, 1'b0);
        applyStimulus(0, 0, 1'b0, 10, 1'b0);
        applyStimulus(1, 0, 1'b0, -1, 1'b0);
        applyStimulus(2, 0, 1'b0, MAX, 1'b0);
        applyStimulus(2, 1, 1'b0, 7, 1'b1);

        // Reset partway through a four-byte load
        start    = 1'b1;
        ld_len   = 9'd4;
        @(negedge clk);
        start    = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ld_valid = 1'b1;
            ld_data  = 8'($urandom);
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        ld_valid = 1'b0;
        checkOutput("midRstCoreRst", core_reset, 1);
        checkOutput("midRstWrEn", mem_wr_en, 0);
        checkOutput("midRstReady", ld_ready, 0);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstAddr", mem_addr, 0);
        checkOutput("midRstSum", ld_sum, 0);
        applyStimulus(4, 0, 1'b0, 2, 1'b0);

        applyStimulus(256, 0, 1'b0, 0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            applyStimulus(int'($urandom_range(6, 0)), -1, 1'b0,
                          int'($urandom_range(MAX + 2, 0)) - 1, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
